reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
Pending-write tracker for the 32-entry register file, indexed by the same 5-bit register addresses that the enable-gated address flip-flops carry down the pipeline.
- The issue stage marks a destination register pending when it writes an instruction.
- The writeback stage retires the pending write.
- The issue stage reads the table to detect source/destination hazards and generates the stall.
- Sits between decode/issue and writeback; it is the read/consume end of the writeback address path.

Parameters:
NREG, 32, number of architectural registers
AW, 5, register address width (log2 NREG)
CW, 2, per-register pending-write counter width (max outstanding = 2^CW-1 = 3)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
iss_valid  input  1  issue stage presents an instruction this cycle
iss_wen  input  1  instruction writes a destination register
iss_rd  input  AW  destination register address
rs_a  input  AW  source operand A address
rs_b  input  AW  source operand B address
wb_valid  input  1  writeback retires one write this cycle
wb_rd  input  AW  register address being retired
stall  output  1  issue must hold; instruction not accepted
iss_fire  output  1  instruction accepted this cycle (iss_valid & ~stall)
busy_vec  output  NREG  bit i = register i has ≥1 pending write
err  output  1  sticky: retire to a register with zero pending writes

Behaviour:
- State: NREG counters cnt[i] of CW bits, plus the err flag.
- Reset (rst=0, asynchronous): all cnt=0, err=0. Outputs: busy_vec=0, stall=0, iss_fire=0 (these are combinational from state/inputs).
- Register 0 is hardwired: cnt[0] never changes. An issue or retire to r0 is ignored, is never busy and never sets err.
- busy_vec[i] = (cnt[i]!=0); combinational from registered state only.
- Hazard: haz_a = busy_vec[rs_a]; haz_b = busy_vec[rs_b]; haz_full = iss_wen & (cnt[iss_rd]==3).
- stall = iss_valid & (haz_a | haz_b | haz_full).
- iss_fire = iss_valid & ~stall.
- No same-cycle bypass: a wb_valid in cycle N does not clear a hazard until cycle N+1.
- Update at rising clk, per register i≠0:
  - inc = iss_fire & iss_wen & (iss_rd==i)
  - dec = wb_valid & (wb_rd==i) & (cnt[i]!=0)
  - inc & ~dec: cnt+1
  - dec & ~inc: cnt-1
  - inc & dec: unchanged
- Counter never wraps: increment at 3 is prevented by stall; decrement at 0 is prevented by the dec term.
- err is set at the clock edge when wb_valid & wb_rd≠0 & cnt[wb_rd]==0. It stays set until reset.
- Latency: issue marks busy visible next cycle; retire clears busy visible next cycle.
- Reset asserted mid-operation clears all pending state immediately; in-flight retires after reset release are then treated as errors.

Decomposition:
- Shared package: NREG, AW, CW constants; R0 = 0 constant; CNT_MAX = 2^CW-1.
- Sub-module sb_counter: one CW-bit up/down counter.
  - Inputs: clk, rst, inc, dec.
  - Outputs: cnt, nz, full.
  - Instantiated NREG-1 times (r1..r31) via generate; r0 is tied to constant zero.
- Top level holds the address decoders, hazard muxes and the err flop.

Test Plan:
1. Reset, then issue with iss_wen=1, iss_rd=5, rs_a=1, rs_b=2 -> iss_fire=1; next cycle busy_vec=0x0000_0020.
2. r5 busy; issue with rs_a=5 -> stall=1, iss_fire=0. Then wb_valid with wb_rd=5 -> in the wb cycle stall is still 1; next cycle busy_vec[5]=0 and stall=0.
3. Three back-to-back issues to rd=7 with no retire -> cnt[7]=3; fourth issue to rd=7 -> stall=1 (haz_full). One retire of r7 -> fourth issue fires the cycle after.
4. cnt[9]=1; same cycle issue to rd=9 and wb to r9 -> cnt[9] stays 1 and busy_vec[9]=1; then a single retire -> busy_vec[9]=0.
5. wb_valid with wb_rd=12 while cnt[12]=0 -> err=1 next cycle and stays 1; wb to r0 -> no err; issue with rd=0 -> busy_vec stays 0.
6. r3 and r4 pending; drop rst low asynchronously between clock edges -> busy_vec=0 and err=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared constants for the register pending-write scoreboard.
//   NREG    - number of architectural registers
//   AW      - register address width
//   CW      - per-register pending-write counter width
//   R0      - hardwired zero register address
//   CNT_MAX - largest count a per-register counter can hold
package reg_scoreboard_pkg;

  localparam int unsigned NREG    = 32;
  localparam int unsigned AW      = 5;
  localparam int unsigned CW      = 2;
  localparam logic [AW-1:0] R0    = '0;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

endpackage

// File: rtl/reg_scoreboard_counter.sv
// sb_counter: one saturating-by-construction up/down pending-write counter.
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   inc  - one more write issued to this register
//   dec  - one pending write retired from this register
//   cnt  - current number of outstanding writes
//   nz   - cnt != 0 (register busy)
//   full - cnt == CNT_MAX (no further issue may be accepted)
module sb_counter
  import reg_scoreboard_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          nz,
  output logic          full
);

  assign nz   = (cnt != '0);
  assign full = (cnt == CW'(CNT_MAX));

  // Simultaneous inc and dec cancel; the full/nz guards keep the count from wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && !dec && !full) begin
      cnt <= cnt + CW'(1);
    end else if (dec && !inc && nz) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-write tracker for the register file.
//   clk       - system clock, rising edge
//   rst       - asynchronous active-low reset
//   iss_valid - issue stage presents an instruction
//   iss_wen   - instruction writes iss_rd
//   iss_rd    - destination register address
//   rs_a/rs_b - source operand addresses
//   wb_valid  - writeback retires one write to wb_rd
//   wb_rd     - register address being retired
//   stall     - issue must hold (source busy or destination counter full)
//   iss_fire  - instruction accepted this cycle
//   busy_vec  - bit i set while register i has a pending write
//   err       - sticky: retire seen for a register with no pending write
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic            iss_wen,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   rs_a,
  input  logic [AW-1:0]   rs_b,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  output logic            stall,
  output logic            iss_fire,
  output logic [NREG-1:0] busy_vec,
  output logic            err
);

  logic [CW-1:0]   cnt [NREG];
  logic [NREG-1:0] full_vec;
  logic            haz_a;
  logic            haz_b;
  logic            haz_full;

  // r0 is hardwired: never counts, never busy, never full.
  assign cnt[0]      = '0;
  assign busy_vec[0] = 1'b0;
  assign full_vec[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_reg
    logic inc;
    logic dec;

    assign inc = iss_fire & iss_wen & (iss_rd == AW'(i));
    assign dec = wb_valid & (wb_rd == AW'(i)) & busy_vec[i];

    sb_counter u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc),
      .dec  (dec),
      .cnt  (cnt[i]),
      .nz   (busy_vec[i]),
      .full (full_vec[i])
    );
  end

  // Hazards look only at registered state, so a same-cycle retire does not bypass.
  assign haz_a    = busy_vec[rs_a];
  assign haz_b    = busy_vec[rs_b];
  assign haz_full = iss_wen & full_vec[iss_rd];
  assign stall    = iss_valid & (haz_a | haz_b | haz_full);
  assign iss_fire = iss_valid & ~stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (wb_valid && (wb_rd != R0) && (cnt[wb_rd] == '0)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic        iss_wen;
  logic [4:0]  iss_rd;
  logic [4:0]  rs_a;
  logic [4:0]  rs_b;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        stall;
  logic        iss_fire;
  logic [31:0] busy_vec;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: number of outstanding writes per register, sticky error.
  int m_cnt [32];
  bit m_err;

  reg_scoreboard dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_wen   (iss_wen),
    .iss_rd    (iss_rd),
    .rs_a      (rs_a),
    .rs_b      (rs_b),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .stall     (stall),
    .iss_fire  (iss_fire),
    .busy_vec  (busy_vec),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model-based compare on every falling edge, then advance the model to
  // the state the next rising edge should produce.
  always @(negedge clk) begin
    logic [31:0] e_busy;
    bit          e_stall;
    bit          e_fire;
    bit          do_inc;
    bit          do_dec;
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_err = 1'b0;
    end
    e_busy = '0;
    for (int i = 1; i < 32; i++) e_busy[i] = (m_cnt[i] > 0);
    e_stall = iss_valid && ((m_cnt[rs_a] > 0) || (m_cnt[rs_b] > 0) ||
                            (iss_wen && m_cnt[iss_rd] == 3));
    e_fire  = iss_valid && !e_stall;
    chk("m_busy_vec", busy_vec, e_busy);
    chk("m_stall", {31'b0, stall}, {31'b0, e_stall});
    chk("m_iss_fire", {31'b0, iss_fire}, {31'b0, e_fire});
    chk("m_err", {31'b0, err}, {31'b0, m_err});
    if (rst) begin
      do_inc = e_fire && iss_wen && iss_rd != 0;
      do_dec = wb_valid && wb_rd != 0 && m_cnt[wb_rd] > 0;
      if (wb_valid && wb_rd != 0 && m_cnt[wb_rd] == 0) m_err = 1'b1;
      if (do_dec) m_cnt[wb_rd] = m_cnt[wb_rd] - 1;
      if (do_inc) m_cnt[iss_rd] = m_cnt[iss_rd] + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 0; iss_wen = 0; iss_rd = 0; rs_a = 0; rs_b = 0;
    wb_valid = 0; wb_rd = 0;
  endtask

  task automatic issue(input logic wen, input logic [4:0] rd,
                       input logic [4:0] a, input logic [4:0] b);
    iss_valid = 1; iss_wen = wen; iss_rd = rd; rs_a = a; rs_b = b;
  endtask

  task automatic retire(input logic [4:0] rd);
    wb_valid = 1; wb_rd = rd;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #1;
    chk("reset_busy", busy_vec, 32'h0);
    chk("reset_stall", {31'b0, stall}, 32'h0);
    chk("reset_fire", {31'b0, iss_fire}, 32'h0);
    chk("reset_err", {31'b0, err}, 32'h0);
    #11 rst = 1'b1;

    // 1: issue to r5, busy next cycle
    step(); issue(1, 5, 1, 2); #1;
    chk("t1_fire", {31'b0, iss_fire}, 32'h1);
    step(); idle(); #1;
    chk("t1_busy", busy_vec, 32'h0000_0020);

    // 2: RAW hazard on r5, no same-cycle bypass on retire
    issue(0, 0, 5, 0); #1;
    chk("t2_stall", {31'b0, stall}, 32'h1);
    chk("t2_nofire", {31'b0, iss_fire}, 32'h0);
    step(); retire(5); #1;
    chk("t2_stall_wb", {31'b0, stall}, 32'h1);
    step(); wb_valid = 0; #1;
    chk("t2_busy_clr", busy_vec, 32'h0);
    chk("t2_fire", {31'b0, iss_fire}, 32'h1);
    step(); idle();

    // 3: fill r7 to three outstanding writes, fourth stalls
    for (int k = 0; k < 3; k++) begin
      issue(1, 7, 0, 0); #1;
      chk("t3_fill_fire", {31'b0, iss_fire}, 32'h1);
      step();
    end
    #1;
    chk("t3_full_stall", {31'b0, stall}, 32'h1);
    step(); retire(7); #1;
    chk("t3_stall_wb", {31'b0, stall}, 32'h1);
    step(); wb_valid = 0; #1;
    chk("t3_fire_after", {31'b0, iss_fire}, 32'h1);
    step(); idle(); retire(7);
    step(); step(); step(); idle(); #1;
    chk("t3_drained", busy_vec, 32'h0);

    // 4: simultaneous issue and retire on r9 cancel
    issue(1, 9, 0, 0);
    step(); retire(9); #1;
    chk("t4_fire", {31'b0, iss_fire}, 32'h1);
    step(); idle(); #1;
    chk("t4_busy", busy_vec, 32'h0000_0200);
    retire(9);
    step(); idle(); #1;
    chk("t4_clr", busy_vec, 32'h0);

    // 5: r0 ignored; unmatched retire sets sticky err
    retire(0);
    step(); idle(); #1;
    chk("t5_r0_noerr", {31'b0, err}, 32'h0);
    issue(1, 0, 0, 0);
    step(); idle(); #1;
    chk("t5_r0_notbusy", busy_vec, 32'h0);
    retire(12);
    step(); idle(); #1;
    chk("t5_err", {31'b0, err}, 32'h1);
    step(); step(); #1;
    chk("t5_err_sticky", {31'b0, err}, 32'h1);

    // 6: asynchronous reset with r3, r4 pending
    issue(1, 3, 0, 0);
    step(); issue(1, 4, 0, 0);
    step(); idle(); #1;
    chk("t6_busy", busy_vec, 32'h0000_0018);
    #1 rst = 1'b0;
    #1;
    chk("t6_async_busy", busy_vec, 32'h0);
    chk("t6_async_err", {31'b0, err}, 32'h0);
    step(); #2 rst = 1'b1;
    step(); retire(3);
    step(); idle(); #1;
    chk("t6_stale_retire_err", {31'b0, err}, 32'h1);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
